// File: rtl/home_sensor_frontend_if.sv
// Serial temperature sensor bus between the acquisition front-end and the sensor.
interface home_sensor_frontend_if;
  logic ts_cs_n;
  logic ts_sck;
  logic ts_miso;

  modport master (output ts_cs_n, output ts_sck, input ts_miso);
  modport slave  (input ts_cs_n, input ts_sck, output ts_miso);
endinterface

// File: rtl/home_sensor_frontend.sv
// Sensor front-end: four debounced contact channels plus a periodic 8-bit serial temperature read.
// Optional HAS_TEMP_AVG_EN: ST reports the 4-sample running average of good readings.

module hsf_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_raw,
  output logic o_out
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_out;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_out  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_out) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES-1)) begin
        r_out <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_out = r_out;
endmodule

module home_sensor_frontend #(
  parameter int DEB_CYCLES    = 16,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int SCK_DIV       = 4,
  parameter int ST_RESET      = 60
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   raw_fd,
  input  logic                   raw_rd,
  input  logic                   raw_w,
  input  logic                   raw_fa,
  output logic                   SFD,
  output logic                   SRD,
  output logic                   SW,
  output logic                   SFA,
  home_sensor_frontend_if.master ts,
  output logic [6:0]             ST,
  output logic                   st_valid,
  output logic                   st_err
);
  localparam int NUM_LANES = 4;
  localparam int TW        = $clog2(SAMPLE_PERIOD);
  localparam int DW        = $clog2(SCK_DIV+1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  logic [NUM_LANES-1:0] w_raw, w_deb;

  assign w_raw = {raw_fa, raw_w, raw_rd, raw_fd};

  hsf_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_LANES-1:0] (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_raw (w_raw),
    .o_out (w_deb)
  );

  assign {SFA, SW, SRD, SFD} = w_deb;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_div;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_cs_n, r_sck, r_valid, r_err;
  logic [6:0]    r_st;
  logic [6:0]    w_sat;
  logic          w_last;

  assign w_sat  = r_sh[7] ? 7'd127 : r_sh[6:0];
  assign w_last = (r_div == DW'(SCK_DIV-1));

`ifdef HAS_TEMP_AVG_EN
  // Three previous good samples; the incoming sample is the fourth history entry.
  logic [2:0][6:0] r_hist;
  logic [8:0]      w_sum;
  assign w_sum = 9'(r_hist[0]) + 9'(r_hist[1]) + 9'(r_hist[2]) + 9'(w_sat);
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_div   <= '0;
      r_bit   <= 3'd7;
      r_sh    <= '0;
      r_cs_n  <= 1'b1;
      r_sck   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_st    <= 7'(ST_RESET);
`ifdef HAS_TEMP_AVG_EN
      r_hist  <= {3{7'(ST_RESET)}};
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_timer == TW'(SAMPLE_PERIOD-1)) begin
            r_timer <= '0;
            r_div   <= '0;
            r_cs_n  <= 1'b0;
            r_state <= SETUP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        SETUP: begin
          if (w_last) begin
            r_div   <= '0;
            r_bit   <= 3'd7;
            r_state <= SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        SHIFT: begin
          if (!w_last) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
              r_sh  <= {r_sh[6:0], ts.ts_miso};
            end else begin
              r_sck <= 1'b0;
              if (r_bit == 3'd0) begin
                // Result is published on entry so ST/st_err are valid alongside st_valid.
                r_state <= DONE;
                r_cs_n  <= 1'b1;
                r_valid <= 1'b1;
                if (r_sh == 8'hFF) begin
                  r_err <= 1'b1;
                end else begin
                  r_err <= 1'b0;
`ifdef HAS_TEMP_AVG_EN
                  r_hist <= {r_hist[1:0], w_sat};
                  r_st   <= 7'(w_sum >> 2);
`else
                  r_st   <= w_sat;
`endif
                end
              end else begin
                r_bit <= r_bit - 1'b1;
              end
            end
          end
        end
        DONE: begin
          r_timer <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ts.ts_cs_n = r_cs_n;
  assign ts.ts_sck  = r_sck;
  assign ST         = r_st;
  assign st_valid   = r_valid;
  assign st_err     = r_err;
endmodule

// File: tb/tb_home_sensor_frontend.sv
// Scoreboard bench: stimulus pushes expected contact edges and conversion results, monitors pop and compare.
module tb_home_sensor_frontend;
  localparam int DEB = 16;
  localparam int SP  = 1000;
  localparam int SD  = 4;
  localparam int STR = 60;

  typedef struct { logic [6:0] st; logic err; } exp_t;
  typedef struct { int cyc; logic val; } dexp_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] raw_v = 4'b0;
  logic       SFD, SRD, SW, SFA;
  logic [6:0] ST;
  logic       st_valid, st_err;
  wire  [3:0] outs = {SFA, SW, SRD, SFD};

  home_sensor_frontend_if tsif();

  home_sensor_frontend dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .raw_fd   (raw_v[0]),
    .raw_rd   (raw_v[1]),
    .raw_w    (raw_v[2]),
    .raw_fa   (raw_v[3]),
    .SFD      (SFD),
    .SRD      (SRD),
    .SW       (SW),
    .SFA      (SFA),
    .ts       (tsif),
    .ST       (ST),
    .st_valid (st_valid),
    .st_err   (st_err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int npass = 0, ntot = 0;
  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: latest (or 4-sample averaged) saturated reading, 0xFF means absent.
  exp_t       exp_q[$];
  dexp_t      deb_q[4][$];
  logic [7:0] forced_q[$];
  int         m_hist[$];
  int         m_last;

  task automatic model_reset();
    m_last = STR;
    m_hist = '{STR, STR, STR, STR};
    exp_q.delete();
  endtask

  task automatic model_push(input logic [7:0] b);
    exp_t e;
    int   sat, s;
    if (b == 8'hFF) begin
      e.err = 1'b1;
      e.st  = 7'(m_last);
    end else begin
      sat = (b > 127) ? 127 : int'(b);
`ifdef HAS_TEMP_AVG_EN
      m_hist.push_back(sat);
      void'(m_hist.pop_front());
      s = 0;
      foreach (m_hist[i]) s += m_hist[i];
      m_last = s / 4;
`else
      s = sat;
      m_last = s;
`endif
      e.err = 1'b0;
      e.st  = 7'(m_last);
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'hFF;
    if (r <= 3) return 8'($urandom_range(128, 254));
    return 8'($urandom_range(0, 127));
  endfunction

  // Sensor: presents MSB first from chip-select fall, advances on each sck fall.
  logic [7:0] cur_byte = 8'h00;
  logic [2:0] idx = 3'd7;
  int         sck_rises = 0;
  assign tsif.ts_miso = cur_byte[idx];

  always @(negedge tsif.ts_cs_n) if (Rst === 1'b1) begin
    if (forced_q.size() > 0) cur_byte = forced_q.pop_front();
    else cur_byte = rand_byte();
    idx = 3'd7;
    sck_rises = 0;
    model_push(cur_byte);
  end

  always @(negedge tsif.ts_sck) if (!tsif.ts_cs_n) idx = idx - 3'd1;
  always @(posedge tsif.ts_sck) sck_rises++;

  logic [3:0] prev_out = 4'b0;
  logic       prev_valid = 1'b0;
  int         cs_low = 0, nconv = 0;
  dexp_t      mon_d;
  exp_t       mon_e;

  always @(negedge Clk) if (Rst) begin
    for (int ch = 0; ch < 4; ch++) if (outs[ch] !== prev_out[ch]) begin
      if (deb_q[ch].size() == 0) chk($sformatf("deb_unexpected_ch%0d", ch), 1, 0);
      else begin
        mon_d = deb_q[ch].pop_front();
        chk($sformatf("deb_cycle_ch%0d", ch), cyc, mon_d.cyc);
        chk($sformatf("deb_val_ch%0d", ch), int'(outs[ch]), int'(mon_d.val));
      end
    end
    prev_out = outs;
    if (!tsif.ts_cs_n) cs_low++;
    if (st_valid) begin
      chk("st_valid_width", int'(prev_valid), 0);
      chk("sck_rises", sck_rises, 8);
      chk("cs_low_cycles", cs_low, 17*SD);
      if (exp_q.size() == 0) chk("conv_unexpected", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("ST", int'(ST), int'(mon_e.st));
        chk("st_err", int'(st_err), int'(mon_e.err));
      end
      cs_low = 0;
      nconv++;
    end
    prev_valid = st_valid;
  end

  task automatic apply_reset();
    Rst = 1'b0;
    model_reset();
    for (int ch = 0; ch < 4; ch++) deb_q[ch].delete();
    prev_out = 4'b0;
    prev_valid = 1'b0;
    cs_low = 0;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
  endtask

  // len==0: held edge, expected DEB+2 edges later; len>0: pulse that must be rejected.
  task automatic deb_apply(input logic [3:0] mask, input int len);
    int    c;
    dexp_t d;
    @(negedge Clk);
    c = cyc;
    raw_v = raw_v ^ mask;
    if (len > 0) begin
      repeat (len) @(negedge Clk);
      raw_v = raw_v ^ mask;
    end else begin
      for (int ch = 0; ch < 4; ch++) if (mask[ch]) begin
        d.cyc = c + DEB + 2;
        d.val = raw_v[ch];
        deb_q[ch].push_back(d);
      end
    end
    repeat (DEB + 6) @(negedge Clk);
  endtask

  initial begin
    int n, base;
    model_reset();
    forced_q = '{8'h2D, 8'hC8, 8'hFF};
    #1;
    apply_reset();
    chk("rst_contacts", int'(outs), 0);
    chk("rst_ST", int'(ST), STR);
    chk("rst_st_valid", int'(st_valid), 0);
    chk("rst_st_err", int'(st_err), 0);
    chk("rst_cs_n", int'(tsif.ts_cs_n), 1);
    chk("rst_sck", int'(tsif.ts_sck), 0);

    n = 0;
    while (tsif.ts_cs_n && n < 3000) begin @(negedge Clk); n++; end
    chk("first_cs_fall_cycles", n, SP);

    deb_apply(4'b0001, 0);
    deb_apply(4'b0100, 10);
    chk("glitch_SW", int'(SW), 0);
    deb_apply(4'b1010, 0);
    repeat (30)
      deb_apply(4'($urandom_range(1, 15)),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, DEB-1) : 0);
    if (raw_v != 4'b0) deb_apply(raw_v, 0);

    n = 0;
    while (nconv < 10 && n < 15000) begin @(negedge Clk); n++; end
    chk("conv_count", int'(nconv >= 10), 1);
    for (int ch = 0; ch < 4; ch++) chk($sformatf("deb_pending_ch%0d", ch), deb_q[ch].size(), 0);

    n = 0;
    while (tsif.ts_cs_n && n < 3000) begin @(negedge Clk); n++; end
    while (!(sck_rises == 3 && !tsif.ts_sck) && n < 6000) begin @(negedge Clk); n++; end
    chk("reach_bit4", int'(n < 6000), 1);
    #2;
    Rst = 1'b0;
    #1;
    chk("abort_cs_n", int'(tsif.ts_cs_n), 1);
    chk("abort_sck", int'(tsif.ts_sck), 0);
    chk("abort_ST", int'(ST), STR);
    forced_q = '{8'd40, 8'd40, 8'd40, 8'd40};
    apply_reset();
    base = nconv;
    n = 0;
    while (nconv < base + 4 && n < 6000) begin @(negedge Clk); n++; end
    chk("avg_conv_count", nconv - base, 4);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/home_sensor_frontend.md
Name: home_sensor_frontend

Overview:
Sensor acquisition front-end for the home automation controller. It produces that controller's inputs from raw hardware.
- Debounces the four raw contact sensors (front door, rear door, window, fire alarm) into clean SFD/SRD/SW/SFA levels.
- Periodically reads an 8-bit serial temperature sensor and presents a saturated 7-bit ST value.

Parameters:
DEB_CYCLES, 16, consecutive stable synchronized cycles required before a contact output changes (>=2)
SAMPLE_PERIOD, 1000, Clk cycles spent in IDLE between temperature conversions (>=4)
SCK_DIV, 4, Clk cycles per half-period of ts_sck (>=1)
ST_RESET, 60, ST value after reset; must lie inside the 50..70 no-action band

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst  input  1  asynchronous, active-low reset (0 = reset asserted); one clock
raw_fd  input  1  raw front-door contact, asynchronous to Clk
raw_rd  input  1  raw rear-door contact, asynchronous
raw_w  input  1  raw window contact, asynchronous
raw_fa  input  1  raw fire-alarm contact, asynchronous
SFD  output  1  debounced front door
SRD  output  1  debounced rear door
SW  output  1  debounced window
SFA  output  1  debounced fire alarm
ts_cs_n  output  1  temperature sensor chip select, active-low
ts_sck  output  1  temperature sensor serial clock, idle low
ts_miso  input  1  sensor data, MSB first, stable around ts_sck rising edge
ST  output  7  current temperature, unsigned degrees
st_valid  output  1  one-cycle pulse when a conversion completes (good or errored)
st_err  output  1  last conversion read 0xFF (sensor absent)

Behaviour:
Reset (Rst=0, async):
- SFD/SRD/SW/SFA=0, ST=ST_RESET, st_valid=0, st_err=0, ts_cs_n=1, ts_sck=0.
- FSM goes to IDLE; IDLE timer=0; all debounce counters=0; sync flops=0.

Contact debounce (four identical channels):
- Raw input passes through a 2-flop synchronizer.
- Per channel, cnt resets to 0 when sync==out; otherwise cnt increments.
- When cnt==DEB_CYCLES-1 and sync!=out: out<=sync, cnt<=0.
- A clean raw edge therefore reaches the output 2+DEB_CYCLES rising edges later.
- Any glitch shorter than DEB_CYCLES synchronized cycles is rejected, and the counter restarts.
- Channels are fully independent; simultaneous changes on several channels all update on the same edge.

Temperature FSM (IDLE, SETUP, SHIFT, DONE):
- IDLE: ts_cs_n=1, ts_sck=0. Timer counts 0..SAMPLE_PERIOD-1; on the terminal count go to SETUP.
- SETUP: ts_cs_n=0 for SCK_DIV cycles, then go to SHIFT with bit index 7.
- SHIFT:
  - Per bit: ts_sck low for SCK_DIV cycles, then high for SCK_DIV cycles.
  - ts_miso is captured into the shift register on the Clk edge where ts_sck goes 0->1.
  - After bit 0's high phase, ts_sck returns to 0 and the FSM goes to DONE.
- DONE (1 cycle):
  - ts_cs_n=1 and st_valid=1.
  - If the byte is 0xFF: st_err<=1 and ST holds.
  - Otherwise: st_err<=0 and ST<=min(byte,127). Bytes 128..254 saturate to 127.
  - Next state is IDLE with timer=0.
- Timing: the first conversion begins SAMPLE_PERIOD cycles after reset release. A conversion occupies SCK_DIV*17+1 cycles.
- Reset mid-conversion aborts immediately: cs deasserts and ST keeps its reset value.
- st_valid is never high for more than one consecutive cycle.

Optional Feature:
Macro: HAS_TEMP_AVG_EN.
- Defined:
  - A 4-entry history of saturated good samples is kept; on reset every entry is ST_RESET.
  - In DONE, a good sample shifts into the history.
  - ST = (sum of the 4 entries, 9-bit) >> 2, truncated, registered in the same DONE cycle.
  - Errored (0xFF) samples do not enter the history.
- Undefined: ST is the latest saturated sample, as described above.

Test Plan:
1. Reset then idle: Rst=0 for 3 cycles, then 1, no raw activity -> all contacts 0, ST=60, st_valid=0; ts_cs_n first falls exactly 1000 cycles after release.
2. Clean edge and glitch: raw_fd 0->1 held -> SFD=1 exactly 18 edges later. raw_w pulse of 10 cycles -> SW stays 0.
3. Simultaneous edges: raw_rd and raw_fa rise on the same cycle -> SRD and SFA rise on the same edge.
4. Good conversion: sensor model returns 0x2D -> exactly 8 ts_sck rising edges; ST=45; st_valid one cycle; st_err=0.
5. Saturation and sensor absent: 0xC8 -> ST=127. Then ts_miso tied high (0xFF) -> st_err=1 and ST stays 127.
6. Mid-conversion reset: Rst=0 during the 4th bit -> ts_cs_n=1 and ts_sck=0 immediately; ST=60. With HAS_TEMP_AVG_EN: samples 40,40,40,40 after reset -> ST sequence 55,50,45,40.
